t02_lcd_ctrl: RTL and testbench

T02_LCD_CTRL -- requirements
Module: t02_lcd_ctrl

---
 rtl/t02_lcd_pkg.sv | 48 ++++
 rtl/t02_lcd_slot_timer.sv | 26 ++
 rtl/t02_lcd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_t02_lcd_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t02_lcd_pkg.sv
// Shared types and constants for the character-LCD refresh controller.
package t02_lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_ADDR,
    ST_CHAR,
    ST_IDLE
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNC8_1L = 8'h30;
  localparam logic [7:0] CMD_FUNC8_2L = 8'h38;
  localparam logic [7:0] CMD_FUNC4_1L = 8'h20;
  localparam logic [7:0] CMD_FUNC4_2L = 8'h28;
  localparam logic [7:0] CMD_DISP_OFF = 8'h08;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] BOOT_NIB_3   = 8'h30;
  localparam logic [7:0] BOOT_NIB_2   = 8'h20;

  // 4-bit mode prepends four bootstrap nibbles (steps 0..3) ahead of the byte commands.
  function automatic logic [7:0] init_cmd(input logic [3:0] step, input logic bus4,
                                          input logic multi_row);
    logic [3:0] idx;
    if (bus4 && step < 4'd4) return (step == 4'd3) ? BOOT_NIB_2 : BOOT_NIB_3;
    idx = bus4 ? step - 4'd4 : step;
    case (idx)
      4'd0:    return bus4 ? (multi_row ? CMD_FUNC4_2L : CMD_FUNC4_1L)
                           : (multi_row ? CMD_FUNC8_2L : CMD_FUNC8_1L);
      4'd1:    return CMD_DISP_OFF;
      4'd2:    return CMD_CLEAR;
      4'd3:    return CMD_ENTRY;
      default: return CMD_DISP_ON;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] cols);
    case (row)
      2'd0:    return 8'h80;
      2'd1:    return 8'hC0;
      2'd2:    return 8'h80 + cols;
      default: return 8'hC0 + cols;
    endcase
  endfunction

endpackage

// File: rtl/t02_lcd_slot_timer.sv
// Free-running transfer-slot counter with slot boundary and enable-window decodes.
module t02_lcd_slot_timer #(
  parameter int unsigned CLK_DIV = 20000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_start,
  output logic slot_last,
  output logic en_window
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             count <= '0;
    else if (count == CW'(CLK_DIV - 1))  count <= '0;
    else                                 count <= count + CW'(1);
  end

  assign slot_start = (count == '0);
  assign slot_last  = (count == CW'(CLK_DIV - 1));
  assign en_window  = (count >= CW'(CLK_DIV / 4)) && (count < CW'(3 * CLK_DIV / 4));

endmodule

// File: rtl/t02_lcd_ctrl.sv
// HD44780-style LCD controller: power-up wait, init sequence, then framed refresh of text.
module t02_lcd_ctrl
  import t02_lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 20000,
  parameter int unsigned PWRUP_SLOTS = 10,
  parameter int unsigned ROWS        = 2,
  parameter int unsigned COLS        = 16,
  parameter int unsigned BUS4        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS*COLS*8-1:0]    text,
  input  logic                      refresh_mode,
  input  logic                      refresh_req,
  output logic                      lcd_en,
  output logic                      lcd_rw,
  output logic                      lcd_rs,
  output logic [7:0]                lcd_data,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned TW        = ROWS * COLS * 8;
  localparam int unsigned PW        = $clog2(PWRUP_SLOTS + 2);
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW        = $clog2(COLS);
  localparam logic        NIB       = (BUS4 != 0);
  localparam logic        MULTI     = (ROWS > 1);
  localparam logic [3:0]  INIT_LAST = NIB ? 4'd8 : 4'd4;

  lcd_state_t     state, n_state;
  logic [PW-1:0]  pwr_cnt;
  logic [3:0]     step, n_step;
  logic [RW-1:0]  row, n_row;
  logic [CW-1:0]  col, n_col;
  logic [TW-1:0]  snap;
  logic [3:0]     lo_nib;
  logic           split, pending;
  logic           slot_start, slot_last, en_window;
  logic           emit, n_rs, start, boot_nib;
  logic [7:0]     n_byte;

  t02_lcd_slot_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_start (slot_start),
    .slot_last  (slot_last),
    .en_window  (en_window)
  );

  // Decodes the slot that follows the current one; applied only on a slot boundary.
  always_comb begin
    n_state  = state;
    n_step   = step;
    n_row    = row;
    n_col    = col;
    emit     = 1'b0;
    n_rs     = 1'b0;
    n_byte   = '0;
    start    = 1'b0;
    boot_nib = 1'b0;
    case (state)
      ST_PWRUP: if (pwr_cnt == PW'(PWRUP_SLOTS)) begin
        n_state = ST_INIT;
        n_step  = '0;
        emit    = 1'b1;
      end
      ST_INIT: begin
        if (step == INIT_LAST) start = 1'b1;
        else begin
          n_step = step + 4'd1;
          emit   = 1'b1;
        end
      end
      ST_ADDR: begin
        n_state = ST_CHAR;
        n_col   = '0;
        emit    = 1'b1;
        n_rs    = 1'b1;
        n_byte  = snap[TW-1 -: 8];
      end
      ST_CHAR: begin
        if (col != CW'(COLS - 1)) begin
          n_col  = col + CW'(1);
          emit   = 1'b1;
          n_rs   = 1'b1;
          n_byte = snap[TW-1 -: 8];
        end else if (row != RW'(ROWS - 1)) begin
          n_state = ST_ADDR;
          n_row   = row + RW'(1);
          emit    = 1'b1;
          n_byte  = row_base(2'(n_row), 8'(COLS));
        end else if (refresh_mode || pending) begin
          start = 1'b1;
        end else begin
          n_state = ST_IDLE;
        end
      end
      ST_IDLE: if (pending) start = 1'b1;
      default: n_state = ST_PWRUP;
    endcase
    if (n_state == ST_INIT && emit) begin
      n_byte   = init_cmd(n_step, NIB, MULTI);
      boot_nib = NIB && (n_step < 4'd4);
    end
    if (start) begin
      n_state = ST_ADDR;
      n_row   = '0;
      emit    = 1'b1;
      n_rs    = 1'b0;
      n_byte  = row_base(2'd0, 8'(COLS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_PWRUP;
      pwr_cnt    <= '0;
      step       <= '0;
      row        <= '0;
      col        <= '0;
      snap       <= '0;
      lo_nib     <= '0;
      split      <= 1'b0;
      pending    <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= slot_last && !split && state == ST_CHAR &&
                    row == RW'(ROWS - 1) && col == CW'(COLS - 1);
      if (slot_start && !split && start) pending <= 1'b0;
      else if (refresh_req)              pending <= 1'b1;
      if (slot_start) begin
        if (split) begin
          split    <= 1'b0;
          lcd_data <= {lo_nib, 4'h0};
        end else begin
          state <= n_state;
          step  <= n_step;
          row   <= n_row;
          col   <= n_col;
          if (state == ST_PWRUP && n_state == ST_PWRUP) pwr_cnt <= pwr_cnt + PW'(1);
          if (emit) begin
            lcd_rs   <= n_rs;
            lo_nib   <= n_byte[3:0];
            split    <= NIB && !boot_nib;
            lcd_data <= NIB ? {n_byte[7:4], 4'h0} : n_byte;
          end
          // The snapshot is consumed MSB-first, one byte per character slot.
          if (start) begin
            snap <= text;
            busy <= 1'b1;
          end else if (n_state == ST_CHAR) begin
            snap <= snap << 8;
          end
          if (n_state == ST_IDLE) busy <= 1'b0;
        end
      end
    end
  end

  assign lcd_en = en_window && (state != ST_PWRUP) && (state != ST_IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_t02_lcd_ctrl.sv
// Directed bench: 8-bit 2x16 controller and 4-bit 4x20 controller checked against transfer tables.
module tb_t02_lcd_ctrl;

  localparam int unsigned CD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [255:0] text_a;
  logic         mode_a, req_a, en_a, rw_a, rs_a, busy_a, fd_a;
  logic [7:0]   data_a;
  logic [639:0] text_b;
  logic         mode_b, req_b, en_b, rw_b, rs_b, busy_b, fd_b;
  logic [7:0]   data_b;

  t02_lcd_ctrl #(.CLK_DIV(CD), .PWRUP_SLOTS(2), .ROWS(2), .COLS(16), .BUS4(0)) dut_a (
    .clk(clk), .rst(rst), .text(text_a), .refresh_mode(mode_a), .refresh_req(req_a),
    .lcd_en(en_a), .lcd_rw(rw_a), .lcd_rs(rs_a), .lcd_data(data_a),
    .busy(busy_a), .frame_done(fd_a)
  );

  t02_lcd_ctrl #(.CLK_DIV(CD), .PWRUP_SLOTS(2), .ROWS(4), .COLS(20), .BUS4(1)) dut_b (
    .clk(clk), .rst(rst), .text(text_b), .refresh_mode(mode_b), .refresh_req(req_b),
    .lcd_en(en_b), .lcd_rw(rw_b), .lcd_rs(rs_b), .lcd_data(data_b),
    .busy(busy_b), .frame_done(fd_b)
  );

  typedef struct {
    string      name;
    int         idx;
    logic [8:0] exp;
  } vec_t;

  vec_t ta[$];
  vec_t tv[$];
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  int n_pass = 0, n_chk = 0;
  int fd_cnt_a = 0, fd_at_a = 0, fd_cnt_b = 0, fd_at_b = 0;
  int fd_wide = 0, nib_bad = 0;
  int base_a = 0, base_b = 0, fdb_base = 0, en_seen;
  logic fd_prev_a = 1'b0, fd_prev_b = 1'b0;
  logic [255:0] old_a, new_a;

  always @(posedge en_a) qa.push_back({rs_a, data_a});
  always @(posedge en_b) qb.push_back({rs_b, data_b});

  always @(negedge clk) begin
    if (fd_a) begin fd_cnt_a++; fd_at_a = qa.size(); end
    if (fd_b) begin fd_cnt_b++; fd_at_b = qb.size(); end
    if ((fd_a && fd_prev_a) || (fd_b && fd_prev_b)) fd_wide++;
    if (data_b[3:0] != 4'h0) nib_bad++;
    fd_prev_a = fd_a;
    fd_prev_b = fd_b;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string n, input int i, input logic rs, input logic [7:0] d);
    vec_t v;
    v.name = n;
    v.idx  = i;
    v.exp  = {rs, d};
    return v;
  endfunction

  function automatic logic [7:0] chr(input logic [255:0] t, input int k);
    return t[255 - k*8 -: 8];
  endfunction

  function automatic int get_a(input int k);
    if (k >= 0 && k < qa.size()) return int'(qa[k]);
    return -1;
  endfunction

  function automatic int get_b(input int k);
    if (k >= 0 && k < qb.size()) return int'(qb[k]);
    return -1;
  endfunction

  task automatic run_table_a(input int base, input int lim);
    foreach (ta[i]) if (ta[i].idx < lim) check(ta[i].name, get_a(base + ta[i].idx), int'(ta[i].exp));
  endtask

  task automatic run_table_b(input int base);
    foreach (tv[i]) check(tv[i].name, get_b(base + tv[i].idx), int'(tv[i].exp));
  endtask

  task automatic wait_xa(input int n);
    int t = 0;
    while (qa.size() < base_a + n && t < 3000) begin @(negedge clk); t++; end
    check("xfer_wait_a", int'(qa.size() >= base_a + n), 1);
  endtask

  task automatic wait_fda(input int n);
    int t = 0;
    while (fd_cnt_a < n && t < 3000) begin @(negedge clk); t++; end
    check("frame_wait_a", int'(fd_cnt_a >= n), 1);
  endtask

  task automatic wait_fdb(input int n);
    int t = 0;
    while (fd_cnt_b < n && t < 3000) begin @(negedge clk); t++; end
    check("frame_wait_b", int'(fd_cnt_b >= n), 1);
  endtask

  task automatic pulse_req_a();
    @(negedge clk) req_a = 1'b1;
    @(negedge clk) req_a = 1'b0;
  endtask

  task automatic count_en_a_16();
    en_seen = 0;
    repeat (16) begin @(negedge clk); if (en_a) en_seen++; end
    check("pwrup_en_low", en_seen, 0);
  endtask

  initial begin
    logic [7:0] init8 [5];
    logic [7:0] init4 [5];
    logic [7:0] rb4   [4];
    logic [255:0] t;
    int fb, k;
    init8 = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    init4 = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
    rb4   = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    old_a = {"HELLO, WORLD!   ", "0123456789ABCDEF"};
    new_a = {"hello, world!   ", "FEDCBA9876543210"};

    // Controller A: init, then frame 1 (old text), frames 2 and 3 (new text).
    for (int i = 0; i < 5; i++) ta.push_back(mk("a_init", i, 1'b0, init8[i]));
    for (int f = 0; f < 3; f++) begin
      fb = 5 + f * 34;
      t  = (f == 0) ? old_a : new_a;
      for (int r = 0; r < 2; r++) begin
        ta.push_back(mk("a_row_addr", fb + r*17, 1'b0, (r == 0) ? 8'h80 : 8'hC0));
        for (int c = 0; c < 16; c++)
          ta.push_back(mk("a_char", fb + r*17 + 1 + c, 1'b1, chr(t, r*16 + c)));
      end
    end
    ta.push_back(mk("a_hello_H", 6, 1'b1, 8'h48));
    ta.push_back(mk("a_hello_E", 7, 1'b1, 8'h45));
    ta.push_back(mk("a_hello_L", 8, 1'b1, 8'h4C));

    // Controller B: bootstrap nibbles, split init bytes, 4 rows x 20 chars as nibble pairs.
    tv.push_back(mk("b_boot", 0, 1'b0, 8'h30));
    tv.push_back(mk("b_boot", 1, 1'b0, 8'h30));
    tv.push_back(mk("b_boot", 2, 1'b0, 8'h30));
    tv.push_back(mk("b_boot", 3, 1'b0, 8'h20));
    for (int i = 0; i < 5; i++) begin
      tv.push_back(mk("b_init_hi", 4 + 2*i, 1'b0, {init4[i][7:4], 4'h0}));
      tv.push_back(mk("b_init_lo", 5 + 2*i, 1'b0, {init4[i][3:0], 4'h0}));
    end
    for (int r = 0; r < 4; r++) begin
      k = 14 + r * 42;
      tv.push_back(mk("b_addr_hi", k,     1'b0, {rb4[r][7:4], 4'h0}));
      tv.push_back(mk("b_addr_lo", k + 1, 1'b0, {rb4[r][3:0], 4'h0}));
      for (int c = 0; c < 20; c++) begin
        tv.push_back(mk("b_char_hi", k + 2 + 2*c, 1'b1, 8'h40));
        tv.push_back(mk("b_char_lo", k + 3 + 2*c, 1'b1, 8'((r + 1) << 4)));
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 20; c++)
        text_b[639 - (r*20 + c)*8 -: 8] = 8'(8'h41 + r);

    rst = 1'b1; text_a = old_a; mode_a = 1'b0; req_a = 1'b0; mode_b = 1'b0; req_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en_a", int'(en_a), 0);
    check("rst_rs_a", int'(rs_a), 0);
    check("rst_data_a", int'(data_a), 0);
    check("rst_rw_a", int'(rw_a), 0);
    check("rst_busy_a", int'(busy_a), 1);
    check("rst_fd_a", int'(fd_a), 0);
    check("rst_en_b", int'(en_b), 0);
    check("rst_data_b", int'(data_b), 0);
    check("rst_busy_b", int'(busy_b), 1);
    rst = 1'b0;

    count_en_a_16();
    check("busy_after_rst", int'(busy_a), 1);

    // Text change and three requests inside frame 1.
    wait_xa(15); text_a = new_a; pulse_req_a();
    wait_xa(25); pulse_req_a();
    wait_xa(35); pulse_req_a();
    wait_fda(1);
    check("frame1_done_at", fd_at_a, 39);
    wait_xa(50);
    check("busy_frame2", int'(busy_a), 1);
    wait_fda(2);
    check("frame2_done_at", fd_at_a, 73);
    repeat (5 * CD) @(negedge clk);
    check("idle_no_extra", qa.size(), 73);
    check("idle_busy", int'(busy_a), 0);
    check("idle_en", int'(en_a), 0);
    check("idle_frames", fd_cnt_a, 2);
    check("idle_data_held", int'({rs_a, data_a}), 9'h130);

    // Request from idle starts exactly one frame.
    pulse_req_a();
    wait_fda(3);
    check("frame3_done_at", fd_at_a, 107);
    run_table_a(0, 107);

    // Continuous mode only takes effect at a frame end.
    mode_a = 1'b1;
    repeat (5 * CD) @(negedge clk);
    check("mode_idle_no_start", qa.size(), 107);
    pulse_req_a();
    wait_fda(4);
    wait_fda(5);
    check("frame5_done_at", fd_at_a, 175);
    wait_xa(176);
    mode_a = 1'b0;
    check("cont_frame5_addr", get_a(141), 9'h080);
    check("cont_frame6_addr", get_a(175), 9'h080);
    wait_fda(6);
    check("frame6_done_at", fd_at_a, 209);
    repeat (5 * CD) @(negedge clk);
    check("cont_stop_count", qa.size(), 209);
    check("cont_stop_busy", int'(busy_a), 0);

    // Reset in the middle of a CHAR run.
    pulse_req_a();
    wait_xa(220);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_en", int'(en_a), 0);
    check("midrst_rs", int'(rs_a), 0);
    check("midrst_data", int'(data_a), 0);
    check("midrst_busy", int'(busy_a), 1);
    check("midrst_fd", int'(fd_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_a = qa.size();
    base_b = qb.size();
    fdb_base = fd_cnt_b;
    count_en_a_16();
    wait_xa(6);
    run_table_a(base_a, 6);

    wait_fdb(fdb_base + 1);
    check("b_frame_done_at", fd_at_b - base_b, 182);
    run_table_b(base_b);
    check("fd_single_cycle", fd_wide, 0);
    check("b_low_nibble_zero", nib_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
